usb_ctrl_out_pio: RTL and testbench



---
 rtl/usb_ctrl_out_pio_pkg.sv | 16 +
 rtl/usb_ctrl_out_pio_if.sv | 23 ++
 rtl/usb_pio_pulse_timer.sv | 61 ++++++
 rtl/usb_ctrl_out_pio.sv | 98 +++++++++
 tb/tb_usb_ctrl_out_pio.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/usb_ctrl_out_pio_pkg.sv
// Shared definitions for the USB control-pin output PIO.
//   ADDR_*        : Avalon register map (DATA, SET, CLEAR, PULSE/STATUS)
//   pulse_state_t : state encoding of the self-timed pulse FSM
package usb_ctrl_out_pio_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLEAR = 2'd2;
  localparam logic [1:0] ADDR_PULSE = 2'd3;

  typedef enum logic {
    IDLE,
    PULSING
  } pulse_state_t;

endpackage

// File: rtl/usb_ctrl_out_pio_if.sv
// Avalon-MM slave bus bundle for the USB control-pin output PIO.
//   address[1:0], chipselect, write, writedata[31:0], read : master -> slave
//   readdata[31:0]                                         : slave -> master
interface usb_ctrl_out_pio_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write, writedata, read,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, writedata, read,
    output readdata
  );

endinterface

// File: rtl/usb_pio_pulse_timer.sv
// Self-timed pulse FSM: after an accepted start, stays busy for exactly
// PULSE_CYCLES clock cycles and flags the last one with a one-cycle expire.
//   clk, reset : clock, synchronous active-high reset
//   start      : request a pulse (ignored unless IDLE)
//   busy       : high while PULSING
//   expire     : high in the final PULSING cycle; the owner clears its pulse bits on that edge
module usb_pio_pulse_timer
  import usb_ctrl_out_pio_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic expire
);

  localparam int unsigned CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(PULSE_CYCLES - 1);

  pulse_state_t   state, state_next;
  logic [CW-1:0]  count, count_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Counter loads only on entry to PULSING and halts at zero, so it never wraps.
  always_comb begin
    state_next = state;
    count_next = count;
    busy       = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = PULSING;
          count_next = LOAD;
        end
      end
      PULSING: begin
        busy = 1'b1;
        if (count == '0) begin
          expire     = 1'b1;
          state_next = IDLE;
        end else begin
          count_next = count - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/usb_ctrl_out_pio.sv
// Avalon-MM output PIO driving the USB controller's control pins.
// Supports direct write, bit set, bit clear and a self-timed pulse on
// selected bits; STATUS reports whether a pulse is running.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : Avalon-MM slave (address, chipselect, write, writedata, read, readdata)
//   out_port    : registered pin levels
//   pulse_busy  : high while a pulse is in progress
module usb_ctrl_out_pio
  import usb_ctrl_out_pio_pkg::*;
#(
  parameter int unsigned      WIDTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int unsigned      PULSE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  usb_ctrl_out_pio_if.slave  bus,
  output logic [WIDTH-1:0]   out_port,
  output logic               pulse_busy
);

  logic [WIDTH-1:0] out_reg, out_next;
  logic [WIDTH-1:0] pulse_mask, mask_next;
  logic [WIDTH-1:0] wd;
  logic [31:0]      rd_next;
  logic             wr_en, rd_en;
  logic             busy, expire, pulse_accept;
  logic             unused_bits;

  assign wd          = bus.writedata[WIDTH-1:0];
  assign unused_bits = ^bus.writedata;
  assign wr_en       = bus.chipselect & bus.write;
  assign rd_en       = bus.chipselect & bus.read;

  // busy is still high in the expiry cycle, so a PULSE write there is dropped.
  assign pulse_accept = wr_en && (bus.address == ADDR_PULSE) && (wd != '0) && !busy;

  usb_pio_pulse_timer #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (pulse_accept),
    .busy   (busy),
    .expire (expire)
  );

  // Expiry clear first, then the bus write on top of it so the write wins.
  always_comb begin
    out_next  = out_reg;
    mask_next = pulse_mask;
    if (expire) begin
      out_next  = out_next & ~pulse_mask;
      mask_next = '0;
    end
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:  out_next = wd;
        ADDR_SET:   out_next = out_next | wd;
        ADDR_CLEAR: out_next = out_next & ~wd;
        ADDR_PULSE: begin
          if (pulse_accept) begin
            out_next  = out_next | wd;
            mask_next = wd;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA:  rd_next[WIDTH-1:0] = out_reg;
      ADDR_PULSE: rd_next[0]         = busy;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg      <= RESET_VALUE;
      pulse_mask   <= '0;
      bus.readdata <= '0;
    end else begin
      out_reg    <= out_next;
      pulse_mask <= mask_next;
      if (rd_en) begin
        bus.readdata <= rd_next;
      end
    end
  end

  assign out_port   = out_reg;
  assign pulse_busy = busy;

endmodule

// File: tb/tb_usb_ctrl_out_pio.sv
// Self-checking bench for usb_ctrl_out_pio (WIDTH=4, RESET_VALUE=0001,
// PULSE_CYCLES=8): vector table, hand-written pulse sequences, and random
// traffic checked against a time-stamp based reference model.
module tb_usb_ctrl_out_pio;
  import usb_ctrl_out_pio_pkg::*;

  localparam int unsigned PC = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] out_port;
  logic       pulse_busy;

  usb_ctrl_out_pio_if bus();

  usb_ctrl_out_pio #(
    .WIDTH        (4),
    .RESET_VALUE  (4'b0001),
    .PULSE_CYCLES (PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .out_port   (out_port),
    .pulse_busy (pulse_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pulse tracked as an absolute end edge, not a counter.
  logic [3:0]  m_out;
  logic [3:0]  m_mask;
  bit          m_active;
  int          m_end;
  logic [31:0] m_rd;
  int          cyc = 0;

  typedef struct {
    bit          rst;
    bit          cs;
    bit          rd;
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [3:0]  e_out;
    bit          e_busy;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit cs, input bit rd, input bit wr,
                            input logic [1:0] a, input logic [31:0] d);
    bit         pre_active;
    logic [3:0] pre_out;
    logic [3:0] w;
    cyc++;
    w = d[3:0];
    if (r) begin
      m_out    = 4'b0001;
      m_mask   = 4'b0000;
      m_active = 1'b0;
      m_rd     = 32'h0;
    end else begin
      pre_active = m_active;
      pre_out    = m_out;
      if (cs && rd) begin
        if (a == 2'd0)      m_rd = {28'h0, pre_out};
        else if (a == 2'd3) m_rd = {31'h0, pre_active};
        else                m_rd = 32'h0;
      end
      if (m_active && cyc == m_end) begin
        m_out    = m_out & ~m_mask;
        m_mask   = 4'b0000;
        m_active = 1'b0;
      end
      if (cs && wr) begin
        case (a)
          2'd0: m_out = w;
          2'd1: m_out = m_out | w;
          2'd2: m_out = m_out & ~w;
          default: begin
            if (!pre_active && w != 4'h0) begin
              m_out    = m_out | w;
              m_mask   = w;
              m_active = 1'b1;
              m_end    = cyc + int'(PC);
            end
          end
        endcase
      end
    end
  endtask

  task automatic step(input bit r, input bit cs, input bit rd, input bit wr,
                      input logic [1:0] a, input logic [31:0] d);
    reset          = r;
    bus.chipselect = cs;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.writedata  = d;
    @(posedge clk);
    model_edge(r, cs, rd, wr, a, d);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_out"},  {28'h0, out_port},   {28'h0, m_out});
    check({tag, "_busy"}, {31'h0, pulse_busy}, {31'h0, m_active});
    check({tag, "_rd"},   bus.readdata,        m_rd);
  endtask

  initial begin
    //          rst   cs    rd    wr    addr  wd            out    busy  rdata
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        4'h1, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        4'h1, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0,        4'h1, 1'b0, 32'h1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        4'h1, 1'b0, 32'h1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'hA,        4'hA, 1'b0, 32'h1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'h4,        4'hE, 1'b0, 32'h1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 32'h8,        4'h6, 1'b0, 32'h1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0,        4'h6, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0,        4'h6, 1'b0, 32'h6};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0,        4'h6, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'hFFFFFFF5, 4'h5, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0,        4'h5, 1'b0, 32'h5};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0,        4'h5, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 32'h0,        4'h5, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,        4'h0, 1'b0, 32'h0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].cs, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd);
      check($sformatf("tbl%0d_out", i),  {28'h0, out_port},   {28'h0, tbl[i].e_out});
      check($sformatf("tbl%0d_busy", i), {31'h0, pulse_busy}, {31'h0, tbl[i].e_busy});
      check($sformatf("tbl%0d_rd", i),   bus.readdata,        tbl[i].e_rd);
    end

    // Pulse on bit 3 from 0000: exactly PC cycles, STATUS, ignored re-trigger.
    step(1'b0, 1'b1, 1'b0, 1'b1, ADDR_PULSE, 32'h8);
    check("pa_start_out", {28'h0, out_port}, 32'h8);
    check("pa_start_busy", {31'h0, pulse_busy}, 32'h1);
    for (int i = 1; i < int'(PC); i++) begin
      if (i == 2)      step(1'b0, 1'b1, 1'b1, 1'b0, ADDR_PULSE, 32'h0);
      else if (i == 4) step(1'b0, 1'b1, 1'b0, 1'b1, ADDR_PULSE, 32'h1);
      else             idle();
      check($sformatf("pa_c%0d_out", i), {28'h0, out_port}, 32'h8);
      check($sformatf("pa_c%0d_busy", i), {31'h0, pulse_busy}, 32'h1);
      if (i == 2) check("pa_status_busy", bus.readdata, 32'h1);
    end
    idle();
    check("pa_end_out", {28'h0, out_port}, 32'h0);
    check("pa_end_busy", {31'h0, pulse_busy}, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, ADDR_PULSE, 32'h0);
    check("pa_status_idle", bus.readdata, 32'h0);
    check("pa_no_retrigger", {31'h0, pulse_busy}, 32'h0);

    // SET in the expiry cycle keeps the pulsed bit high.
    step(1'b0, 1'b1, 1'b0, 1'b1, ADDR_PULSE, 32'h2);
    check("pb_start_out", {28'h0, out_port}, 32'h2);
    for (int i = 1; i < int'(PC); i++) idle();
    step(1'b0, 1'b1, 1'b0, 1'b1, ADDR_SET, 32'h2);
    check("pb_exp_set_out", {28'h0, out_port}, 32'h2);
    check("pb_exp_set_busy", {31'h0, pulse_busy}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, ADDR_CLEAR, 32'h2);
    check("pb_clear_out", {28'h0, out_port}, 32'h0);

    // DATA write mid-pulse; the pulse mask still clears at expiry.
    step(1'b0, 1'b1, 1'b0, 1'b1, ADDR_PULSE, 32'h2);
    for (int i = 1; i < int'(PC); i++) begin
      if (i == 3) begin
        step(1'b0, 1'b1, 1'b0, 1'b1, ADDR_DATA, 32'hF);
        check("pc_data_out", {28'h0, out_port}, 32'hF);
        check("pc_data_busy", {31'h0, pulse_busy}, 32'h1);
      end else begin
        idle();
      end
    end
    idle();
    check("pc_end_out", {28'h0, out_port}, 32'hD);
    check("pc_end_busy", {31'h0, pulse_busy}, 32'h0);

    // Reset mid-pulse aborts it with no later expiry side effect.
    step(1'b0, 1'b1, 1'b0, 1'b1, ADDR_DATA, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, ADDR_PULSE, 32'h4);
    check("pd_start_out", {28'h0, out_port}, 32'h4);
    idle();
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    check("pd_rst_out", {28'h0, out_port}, 32'h1);
    check("pd_rst_busy", {31'h0, pulse_busy}, 32'h0);
    check("pd_rst_rd", bus.readdata, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, ADDR_DATA, 32'h4);
    for (int i = 0; i < 12; i++) idle();
    check("pd_after_out", {28'h0, out_port}, 32'h4);
    check("pd_after_busy", {31'h0, pulse_busy}, 32'h0);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      bit          r, cs, rd, wr;
      logic [1:0]  a;
      logic [31:0] d;
      r  = ($urandom_range(0, 99) == 0);
      cs = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 2) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = $urandom;
      if ($urandom_range(0, 3) == 0) d = d & 32'h0000000F;
      step(r, cs, rd, wr, a, d);
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
